// File: rtl/serial_boot_loader.sv
// Serial boot loader: receives framed words over an asynchronous two-wire
// bit-clock/data link and writes the payload into one of several memories.
module serial_boot_loader #(
  parameter int WORD_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 12,
  parameter int NUM_TARGETS    = 2,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   dataOnPin,
  input  logic                   dataPin,
  output logic [NUM_TARGETS-1:0] wEn,
  output logic [ADDR_WIDTH-1:0]  writeAddr,
  output logic [WORD_WIDTH-1:0]  dataOut,
  output logic                   ready,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  localparam int CNT_W  = $clog2(WORD_WIDTH + 1);
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_CHECK} state_t;

  logic [SYNC_STAGES-1:0] r_on_sync, r_data_sync;
  logic                   r_on_prev;
  logic [WORD_WIDTH-1:0]  r_shift;
  logic [CNT_W-1:0]       r_bitcnt;
  logic [IDLE_W-1:0]      r_idle;

  state_t                 r_state, w_state_next;
  logic [ADDR_WIDTH-1:0]  r_addr, w_addr_next;
  logic [ADDR_WIDTH-1:0]  r_cnt, w_cnt_next;
  logic [WORD_WIDTH-1:0]  r_xor, w_xor_next;
  logic [7:0]             r_target, w_target_next;
  logic                   r_done, w_done_next;
  logic                   r_error, w_error_next;
  logic [NUM_TARGETS-1:0] r_wen, w_wen_next;
  logic [ADDR_WIDTH-1:0]  r_waddr, w_waddr_next;
  logic [WORD_WIDTH-1:0]  r_dout, w_dout_next;
  logic                   r_ready;
  logic                   w_write;

  logic                   w_on, w_din, w_sample, w_word_done, w_timeout;
  logic [7:0]             w_hdr_tgt;
  logic [ADDR_WIDTH-1:0]  w_hdr_n, w_hdr_addr;

  assign w_on        = r_on_sync[SYNC_STAGES-1];
  assign w_din       = r_data_sync[SYNC_STAGES-1];
  assign w_sample    = w_on & ~r_on_prev;
  // A word completes the cycle after its final bit was shifted in.
  assign w_word_done = enable && (r_bitcnt == CNT_W'(WORD_WIDTH));
  // Partial word abandoned by the host; completion takes priority.
  assign w_timeout   = enable && (r_bitcnt != '0) && !w_word_done && !w_sample &&
                       (r_idle == IDLE_W'(TIMEOUT_CYCLES - 1));

  assign w_hdr_tgt  = r_shift[WORD_WIDTH-1 -: 8];
  assign w_hdr_n    = r_shift[2*ADDR_WIDTH-1:ADDR_WIDTH];
  assign w_hdr_addr = r_shift[ADDR_WIDTH-1:0];

  // Synchronize the asynchronous link pins and remember the last bit-clock level.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_on_sync   <= '0;
      r_data_sync <= '0;
      r_on_prev   <= 1'b0;
    end else begin
      r_on_sync[0]   <= dataOnPin;
      r_data_sync[0] <= dataPin;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_on_sync[i]   <= r_on_sync[i-1];
        r_data_sync[i] <= r_data_sync[i-1];
      end
      r_on_prev <= w_on;
    end
  end

  // Shift register, bit counter and inter-bit idle counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_idle   <= '0;
    end else begin
      if (enable && w_sample)
        r_shift <= {r_shift[WORD_WIDTH-2:0], w_din};
      if (!enable || w_timeout)
        r_bitcnt <= '0;
      else if (w_sample)
        r_bitcnt <= (w_word_done ? CNT_W'(0) : r_bitcnt) + CNT_W'(1);
      else if (w_word_done)
        r_bitcnt <= '0;
      if (!enable || w_sample || (r_bitcnt == '0) || w_word_done || w_timeout)
        r_idle <= '0;
      else
        r_idle <= r_idle + IDLE_W'(1);
    end
  end

  // Frame FSM: decodes headers, issues writes, checks the running XOR.
  always_comb begin
    w_state_next  = r_state;
    w_addr_next   = r_addr;
    w_cnt_next    = r_cnt;
    w_xor_next    = r_xor;
    w_target_next = r_target;
    w_done_next   = r_done;
    w_error_next  = r_error;
    w_waddr_next  = r_waddr;
    w_dout_next   = r_dout;
    w_write       = 1'b0;
    if (!enable) begin
      w_state_next = S_IDLE;
      if (r_state != S_IDLE) w_error_next = 1'b1;
    end else if (w_timeout && (r_state != S_IDLE)) begin
      w_state_next = S_IDLE;
      w_error_next = 1'b1;
    end else if (w_word_done) begin
      case (r_state)
        S_IDLE: begin
          if (int'(w_hdr_tgt) < NUM_TARGETS) begin
            w_state_next  = (w_hdr_n == '0) ? S_CHECK : S_DATA;
            w_addr_next   = w_hdr_addr;
            w_cnt_next    = w_hdr_n;
            w_target_next = w_hdr_tgt;
            w_xor_next    = '0;
            w_done_next   = 1'b0;
            w_error_next  = 1'b0;
          end else begin
            // Unknown target: the frame is refused outright.
            w_done_next  = 1'b0;
            w_error_next = 1'b1;
          end
        end
        S_DATA: begin
          w_write      = 1'b1;
          w_waddr_next = r_addr;
          w_dout_next  = r_shift;
          w_addr_next  = r_addr + ADDR_WIDTH'(1);
          w_xor_next   = r_xor ^ r_shift;
          w_cnt_next   = r_cnt - ADDR_WIDTH'(1);
          if (r_cnt == ADDR_WIDTH'(1)) w_state_next = S_CHECK;
        end
        S_CHECK: begin
          w_state_next = S_IDLE;
          if (r_shift == r_xor) w_done_next = 1'b1;
          else                  w_error_next = 1'b1;
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_TARGETS; gi++) begin : g_wen
      assign w_wen_next[gi] = w_write && (r_target == 8'(gi));
    end
  endgenerate

  // FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_cnt    <= '0;
      r_xor    <= '0;
      r_target <= '0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      r_wen    <= '0;
      r_waddr  <= '0;
      r_dout   <= '0;
      r_ready  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_addr   <= w_addr_next;
      r_cnt    <= w_cnt_next;
      r_xor    <= w_xor_next;
      r_target <= w_target_next;
      r_done   <= w_done_next;
      r_error  <= w_error_next;
      r_wen    <= w_wen_next;
      r_waddr  <= w_waddr_next;
      r_dout   <= w_dout_next;
      r_ready  <= w_word_done;
    end
  end

  assign wEn       = r_wen;
  assign writeAddr = r_waddr;
  assign dataOut   = r_dout;
  assign ready     = r_ready;
  assign busy      = (r_state == S_DATA) || (r_state == S_CHECK);
  assign done      = r_done;
  assign error     = r_error;

endmodule

// File: tb/tb_serial_boot_loader.sv
// Directed bench for serial_boot_loader: frames driven bit by bit, writes
// captured by a passive monitor, expectations hand-computed.
module tb_serial_boot_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b1;
  logic        dataOnPin = 1'b0;
  logic        dataPin = 1'b0;
  logic [1:0]  wEn;
  logic [11:0] writeAddr;
  logic [31:0] dataOut;
  logic        ready, busy, done, error;

  int checks = 0;
  int failures = 0;

  int          n_wen = 0;
  int          n_ready = 0;
  logic [1:0]  cap_wen  [32];
  logic [11:0] cap_addr [32];
  logic [31:0] cap_data [32];

  int b_wen, b_ready;

  serial_boot_loader #(
    .WORD_WIDTH(32), .ADDR_WIDTH(12), .NUM_TARGETS(2),
    .SYNC_STAGES(2), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .dataOnPin(dataOnPin), .dataPin(dataPin),
    .wEn(wEn), .writeAddr(writeAddr), .dataOut(dataOut),
    .ready(ready), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Passive monitor: records every write strobe and counts ready pulses.
  always @(negedge clk) begin
    if (ready) n_ready++;
    if (wEn != 2'b00) begin
      if (n_wen < 32) begin
        cap_wen[n_wen]  = wEn;
        cap_addr[n_wen] = writeAddr;
        cap_data[n_wen] = dataOut;
      end
      $display("write wEn=%b addr=%h data=%h", wEn, writeAddr, dataOut);
      n_wen++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [31:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      dataPin = w[31-i];
      repeat (2) @(negedge clk);
      dataOnPin = 1'b1;
      repeat (3) @(negedge clk);
      dataOnPin = 1'b0;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    send_bits(w, 32);
    repeat (6) @(negedge clk);
    $display("word %h sent busy=%b done=%b error=%b", w, busy, done, error);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".wEn"},   64'(wEn), 64'd0);
    chk({tag, ".ready"}, 64'(ready), 64'd0);
    chk({tag, ".busy"},  64'(busy), 64'd0);
    chk({tag, ".done"},  64'(done), 64'd0);
    chk({tag, ".error"}, 64'(error), 64'd0);
    chk({tag, ".addr"},  64'(writeAddr), 64'd0);
    chk({tag, ".data"},  64'(dataOut), 64'd0);
  endtask

  task automatic frame_a(input string tag, input logic [31:0] csum,
                         input logic exp_done, input logic exp_err);
    b_wen = n_wen; b_ready = n_ready;
    send_word(32'h0000_2010);
    chk({tag, ".busy_hdr"}, 64'(busy), 64'd1);
    send_word(32'hDEAD_BEEF);
    send_word(32'h1234_5678);
    send_word(csum);
    chk({tag, ".nwen"},  64'(n_wen - b_wen), 64'd2);
    chk({tag, ".wen0"},  64'(cap_wen[b_wen]), 64'h1);
    chk({tag, ".addr0"}, 64'(cap_addr[b_wen]), 64'h010);
    chk({tag, ".data0"}, 64'(cap_data[b_wen]), 64'hDEADBEEF);
    chk({tag, ".wen1"},  64'(cap_wen[b_wen+1]), 64'h1);
    chk({tag, ".addr1"}, 64'(cap_addr[b_wen+1]), 64'h011);
    chk({tag, ".data1"}, 64'(cap_data[b_wen+1]), 64'h12345678);
    chk({tag, ".ready"}, 64'(n_ready - b_ready), 64'd4);
    chk({tag, ".done"},  64'(done), 64'(exp_done));
    chk({tag, ".error"}, 64'(error), 64'(exp_err));
    chk({tag, ".busy"},  64'(busy), 64'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk_all_zero("rst_during");
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_all_zero("rst_after");

    // Good two-word frame to target 0
    frame_a("frame_good", 32'hCC99_E897, 1'b1, 1'b0);

    // Same frame, bad checksum: writes stay, error raised
    frame_a("frame_badsum", 32'h0000_0000, 1'b0, 1'b1);

    // Target 1, address wrap boundary
    b_wen = n_wen;
    send_word(32'h0100_1FFF);
    send_word(32'hA5A5_A5A5);
    send_word(32'hA5A5_A5A5);
    chk("wrap.nwen",  64'(n_wen - b_wen), 64'd1);
    chk("wrap.wen",   64'(cap_wen[b_wen]), 64'h2);
    chk("wrap.addr",  64'(cap_addr[b_wen]), 64'hFFF);
    chk("wrap.data",  64'(cap_data[b_wen]), 64'hA5A5A5A5);
    chk("wrap.done",  64'(done), 64'd1);
    chk("wrap.error", 64'(error), 64'd0);

    // Out-of-range target
    b_wen = n_wen; b_ready = n_ready;
    send_word(32'h0500_2010);
    repeat (10) @(negedge clk);
    chk("badtgt.nwen",  64'(n_wen - b_wen), 64'd0);
    chk("badtgt.error", 64'(error), 64'd1);
    chk("badtgt.busy",  64'(busy), 64'd0);
    chk("badtgt.ready", 64'(n_ready - b_ready), 64'd1);

    // Timeout after 17 bits of a data word
    b_wen = n_wen;
    send_word(32'h0000_1020);
    chk("tmo.busy_hdr", 64'(busy), 64'd1);
    send_bits(32'h1357_9BDF, 17);
    repeat (130) @(negedge clk);
    chk("tmo.error", 64'(error), 64'd1);
    chk("tmo.busy",  64'(busy), 64'd0);
    chk("tmo.nwen",  64'(n_wen - b_wen), 64'd0);
    frame_a("tmo_next", 32'hCC99_E897, 1'b1, 1'b0);

    // Enable dropped mid-DATA
    b_wen = n_wen;
    send_word(32'h0000_2010);
    send_word(32'h1111_1111);
    chk("ena.nwen1", 64'(n_wen - b_wen), 64'd1);
    send_bits(32'h2222_2222, 10);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    chk("ena.error", 64'(error), 64'd1);
    chk("ena.busy",  64'(busy), 64'd0);
    chk("ena.wen",   64'(wEn), 64'd0);
    repeat (4) @(negedge clk);
    enable = 1'b1;
    send_bits(32'hFFFF_FFFF, 22);
    repeat (150) @(negedge clk);
    chk("ena.nwen_after", 64'(n_wen - b_wen), 64'd1);
    chk("ena.busy_after", 64'(busy), 64'd0);

    // Reset asserted mid-DATA
    b_wen = n_wen;
    send_word(32'h0000_2010);
    send_word(32'h2222_2222);
    chk("mrst.nwen1", 64'(n_wen - b_wen), 64'd1);
    send_bits(32'h3333_3333, 10);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("mrst_during");
    reset = 1'b1;
    @(negedge clk);
    chk_all_zero("mrst_after");
    send_bits(32'hFFFF_FFFF, 22);
    repeat (150) @(negedge clk);
    chk("mrst.nwen_after", 64'(n_wen - b_wen), 64'd1);
    chk("mrst.busy",  64'(busy), 64'd0);
    chk("mrst.error", 64'(error), 64'd0);
    chk("mrst.done",  64'(done), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
